servisia_gpi: RTL and testbench
===============================

Name: servisia_gpi

Overview:
- Wishbone responder for general-purpose inputs; the input counterpart of the GPO peripheral on the core's peripheral bus.
- Synchronizes external pins and keeps sticky rising/falling-edge flags with write-1-to-clear.
- Raises a level interrupt toward the core's timer-IRQ input when a flag is set under an enable mask.
- Placed beside the GPO in the servisia top; the top decodes the address bit that selects GPO or GPI and ORs the acks.

Parameters:
- WIDTH, 8, number of input pins (1..32).
- DEBOUNCE_CYCLES, 4, stable-sample count required when debounce is compiled in (2..255).

Ports:
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  synchronous active-high reset.
- wb_adr_i  input  2  register select; the top wires it to the core address bits [3:2].
- wb_dat_i  input  WIDTH  write data.
- wb_we_i  input  1  write enable.
- wb_stb_i  input  1  strobe; held high by the core until ack.
- wb_rdt_o  output  WIDTH  read data; valid only while wb_ack_o is high.
- wb_ack_o  output  1  one-cycle acknowledge.
- gpio_i  input  WIDTH  asynchronous external pins.
- irq_o  output  1  registered interrupt request.

Behaviour:
- Reset: wb_ack_o=0, wb_rdt_o=0, irq_o=0. LEVEL, RISE, FALL, MASK and the synchronizer flops all clear to 0.
- Synchronizer: 2-flop chain per bit gives sync. LEVEL<=sync, so a pin change is visible in LEVEL 3 cycles after it is sampled.
- Edge detect:
  - rise_ev = sync & ~LEVEL; fall_ev = ~sync & LEVEL.
  - Events are suppressed in the first 3 cycles after reset deassert (a 2-bit settle counter), so pins already high at reset do not flag.
- Registers:
  - adr 0: LEVEL, read-only; writes are ignored.
  - adr 1: RISE, sticky; write-1-to-clear.
  - adr 2: FALL, sticky; write-1-to-clear.
  - adr 3: MASK, read/write.
- Handshake:
  - Accept when wb_stb_i && !wb_ack_o. wb_ack_o goes high the next cycle for exactly 1 cycle, so there is 1 idle cycle between back-to-back accesses.
  - Read data is registered at accept: wb_rdt_o presents the register value as of the accept cycle.
  - Writes take effect at accept.
- W1C vs event in the same cycle: per bit, RISE <= (RISE & ~clr) | rise_ev. Set wins, so no event is lost. FALL follows the same rule.
- irq_o <= |((RISE | FALL) & MASK). Latency is 1 cycle after the flag or mask update.
- Reset mid-transaction: any pending ack is dropped, with no ack in the cycle after reset. The core restarts after reset anyway.
- Widths: bits of wb_dat_i above WIDTH do not exist; the top zero-extends wb_rdt_o to 32 bits.

Optional Feature:
- Macro SERVISIA_GPI_DEBOUNCE_EN.
- When defined:
  - Each bit has a counter after the synchronizer.
  - The filtered value updates only after DEBOUNCE_CYCLES consecutive cycles of sync differing from the filtered value; any glitch resets that bit's counter.
  - Edge detect and LEVEL use the filtered value, adding DEBOUNCE_CYCLES cycles of latency.
- When undefined: the filtered value equals sync; no counters are instantiated.

Decomposition:
- Shared package servisia_pkg: localparams GPI_ADR_LEVEL=0, GPI_ADR_RISE=1, GPI_ADR_FALL=2, GPI_ADR_MASK=3, and GPI_SETTLE_CYCLES=3.
- One sub-module, servisia_gpi_filter:
  - Per-bit synchronizer plus optional debounce, instantiated WIDTH times through a generate loop.
  - Ports: clk, rst, d, q.
- The top module holds the registers, edge logic, handshake and IRQ.

Test Plan:
- Reset, then hold gpio_i=8'hA5 for 10 cycles, then read adr 0 -> rdt=8'hA5, ack exactly 1 cycle after stb. RISE=0 because the pins were high during the settle window.
- Drive gpio_i 8'h00 -> 8'h0F, then read adr 1 -> 8'h0F. Write 8'h03 to adr 1, then read adr 1 -> 8'h0C. Read adr 2 -> 8'h00.
- Write MASK=8'h01, raise gpio_i[1] -> irq_o stays 0. Raise gpio_i[0] -> irq_o=1 at 1 cycle after RISE[0] sets. Write 8'h01 to adr 1 -> irq_o=0 the cycle after ack.
- Schedule a W1C write of adr 1 with 8'h10 in the same cycle as a new rise_ev on bit 4 -> RISE[4] remains 1 on the following read.
- Hold stb high for 6 cycles continuously -> acks on cycles 2, 4 and 6 only, never on consecutive cycles. Assert wb_rst_i while ack is pending -> no ack and rdt=0 afterwards.
- With SERVISIA_GPI_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - A 3-cycle pulse on gpio_i[2] -> no flag.
  - A 5-cycle pulse -> RISE[2]=1 and FALL[2]=1 after it ends.
  - Without the macro, the 3-cycle pulse sets both flags.

Source files
------------

// File: rtl/servisia_pkg.sv
// Shared constants for the servisia peripheral slice: GPI register map and reset settle time.
package servisia_pkg;

  localparam logic [1:0] GPI_ADR_LEVEL = 2'd0;
  localparam logic [1:0] GPI_ADR_RISE  = 2'd1;
  localparam logic [1:0] GPI_ADR_FALL  = 2'd2;
  localparam logic [1:0] GPI_ADR_MASK  = 2'd3;

  localparam int unsigned GPI_SETTLE_CYCLES = 3;

endpackage

// File: rtl/servisia_gpi_filter.sv
// One-bit input conditioner: two-flop synchronizer, plus a stable-count debounce
// when SERVISIA_GPI_DEBOUNCE_EN is defined.
module servisia_gpi_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
    $error("servisia_gpi_filter: DEBOUNCE_CYCLES out of range");
  end

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef SERVISIA_GPI_DEBOUNCE_EN
  logic [7:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  // Any cycle where sync agrees with the filtered value restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign q = filt_q;
`else
  assign q = sync_q;
`endif

endmodule

// File: rtl/servisia_gpi.sv
// Wishbone general-purpose input block: level, sticky rise/fall flags (W1C), mask and IRQ.
// Define SERVISIA_GPI_DEBOUNCE_EN to add a per-bit debounce behind the synchronizer.
module servisia_gpi
  import servisia_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [1:0]       wb_adr_i,
  input  logic [WIDTH-1:0] wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  output logic [WIDTH-1:0] wb_rdt_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq_o
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_param_check
    $error("servisia_gpi: WIDTH out of range");
  end

  localparam logic [1:0] SettleDone = 2'(GPI_SETTLE_CYCLES);

  logic [WIDTH-1:0] filt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filter
    servisia_gpi_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (gpio_i[i]),
      .q   (filt[i])
    );
  end

  logic [1:0]       settle_q, settle_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rdt_q, rdt_d;
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;

  logic             accept, wr_en, ev_en;
  logic [WIDTH-1:0] rise_ev, fall_ev, clr_rise, clr_fall, rd_data;

  always_comb begin
    accept = wb_stb_i & ~ack_q;
    wr_en  = accept & wb_we_i;
    ev_en  = (settle_q == SettleDone);

    // Hold off edge detection until the synchronizer has flushed its reset zeros.
    settle_d = ev_en ? settle_q : settle_q + 2'd1;
    rise_ev  = ev_en ? (filt & ~level_q) : '0;
    fall_ev  = ev_en ? (~filt & level_q) : '0;

    clr_rise = (wr_en && wb_adr_i == GPI_ADR_RISE) ? wb_dat_i : '0;
    clr_fall = (wr_en && wb_adr_i == GPI_ADR_FALL) ? wb_dat_i : '0;

    level_d = filt;
    // A new event beats a clear in the same cycle so no edge is lost.
    rise_d  = (rise_q & ~clr_rise) | rise_ev;
    fall_d  = (fall_q & ~clr_fall) | fall_ev;
    mask_d  = (wr_en && wb_adr_i == GPI_ADR_MASK) ? wb_dat_i : mask_q;

    unique case (wb_adr_i)
      GPI_ADR_LEVEL: rd_data = level_q;
      GPI_ADR_RISE:  rd_data = rise_q;
      GPI_ADR_FALL:  rd_data = fall_q;
      default:       rd_data = mask_q;
    endcase

    rdt_d = accept ? rd_data : '0;
    ack_d = accept;
    irq_d = |((rise_q | fall_q) & mask_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      settle_q <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      mask_q   <= '0;
      rdt_q    <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      settle_q <= settle_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      mask_q   <= mask_d;
      rdt_q    <= rdt_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  assign wb_rdt_o = rdt_q;
  assign wb_ack_o = ack_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_servisia_gpi.sv
// Self-checking bench for servisia_gpi: directed timing checks plus a randomized
// register/pin sequence checked against a flag-level reference model.
module tb_servisia_gpi;

`ifdef SERVISIA_GPI_DEBOUNCE_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] adr = '0;
  logic [7:0] dat = '0;
  logic       we  = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] rdt;
  logic       ack;
  logic [7:0] gpio = '0;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servisia_gpi #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_rdt_o (rdt),
    .wb_ack_o (ack),
    .gpio_i   (gpio),
    .irq_o    (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access; accept lands on the first rising edge after the call's next falling edge.
  task automatic bus_xfer(input logic [1:0] a, input logic w, input logic [7:0] d,
                          output logic [7:0] r);
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk); #1;
    check_eq("ack", {31'd0, ack}, 32'd1);
    r = rdt;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_eq("ack_one_cycle", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] r;
    bus_xfer(a, 1'b1, d, r);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] r;
    bus_xfer(a, 1'b0, 8'h00, r);
    check_eq(tag, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hFF);
  endtask

  logic [7:0] m_pins, m_rise, m_fall, m_mask;

  initial begin
    // Reset with pins already high
    gpio = 8'hA5;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_rdt", {24'd0, rdt}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    wait_cycles(10 + Lat);
    rd_check("level_a5", 2'd0, 8'hA5);
`ifdef SERVISIA_GPI_DEBOUNCE_EN
    rd_check("rise_after_reset", 2'd1, 8'hA5);
`else
    rd_check("rise_after_reset", 2'd1, 8'h00);
`endif
    rd_check("fall_after_reset", 2'd2, 8'h00);
    wr(2'd0, 8'h00);
    rd_check("level_ro", 2'd0, 8'hA5);

    // Rise flags and W1C
    @(negedge clk); gpio = 8'h00;
    wait_cycles(16);
    clear_flags();
    @(negedge clk); gpio = 8'h0F;
    wait_cycles(16);
    rd_check("rise_0f", 2'd1, 8'h0F);
    wr(2'd1, 8'h03);
    rd_check("rise_w1c", 2'd1, 8'h0C);
    rd_check("fall_none", 2'd2, 8'h00);

    // IRQ masking and latency
    @(negedge clk); gpio = 8'h00;
    wait_cycles(16);
    clear_flags();
    wr(2'd3, 8'h01);
    rd_check("mask_rb", 2'd3, 8'h01);
    @(negedge clk); gpio = 8'h02;
    wait_cycles(16);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);
    @(negedge clk); gpio = 8'h03;
    repeat (3 + Lat) @(posedge clk);
    #1 check_eq("irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check_eq("irq_rise", {31'd0, irq}, 32'd1);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 2'd1; dat = 8'h01;
    @(posedge clk); #1;
    check_eq("irq_clr_ack", {31'd0, ack}, 32'd1);
    check_eq("irq_at_ack", {31'd0, irq}, 32'd1);
    @(negedge clk); stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_eq("irq_cleared", {31'd0, irq}, 32'd0);

    // Clear and new event on bit 4 in the same cycle
    clear_flags();
    @(negedge clk); gpio = 8'h13;
    repeat (2 + Lat) @(posedge clk);
    wr(2'd1, 8'h10);
    rd_check("set_beats_clr", 2'd1, 8'h10);

    // Strobe held for six cycles
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("held_stb_ack%0d", i + 2), {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk); stb = 1'b0;
    wait_cycles(2);

    // Reset on the accept cycle
    @(negedge clk);
    stb = 1'b1; adr = 2'd3; rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_mid_rdt", {24'd0, rdt}, 32'd0);
    @(negedge clk); stb = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_ack2", {31'd0, ack}, 32'd0);
    @(negedge clk); rst = 1'b0;
    wait_cycles(16);
    check_eq("rst_mid_rdt2", {24'd0, rdt}, 32'd0);
    check_eq("rst_mid_irq", {31'd0, irq}, 32'd0);
    rd_check("mask_after_rst", 2'd3, 8'h00);
    rd_check("level_after_rst", 2'd0, 8'h13);

    // Short and long pulses on bit 2
    clear_flags();
    @(negedge clk); gpio = 8'h17;
    repeat (3) @(negedge clk);
    gpio = 8'h13;
    wait_cycles(16);
`ifdef SERVISIA_GPI_DEBOUNCE_EN
    rd_check("pulse3_rise", 2'd1, 8'h00);
    rd_check("pulse3_fall", 2'd2, 8'h00);
`else
    rd_check("pulse3_rise", 2'd1, 8'h04);
    rd_check("pulse3_fall", 2'd2, 8'h04);
`endif
    clear_flags();
    @(negedge clk); gpio = 8'h17;
    repeat (5) @(negedge clk);
    gpio = 8'h13;
    wait_cycles(16);
    rd_check("pulse5_rise", 2'd1, 8'h04);
    rd_check("pulse5_fall", 2'd2, 8'h04);

    // Randomized sequence against a flag-level model
    m_pins = 8'h13;
    m_mask = 8'($urandom);
    wr(2'd3, m_mask);
    clear_flags();
    m_rise = '0;
    m_fall = '0;
    for (int it = 0; it < 60; it++) begin
      automatic int         op = $urandom_range(0, 2);
      automatic logic [1:0] a  = 2'($urandom_range(0, 3));
      automatic logic [7:0] v  = 8'($urandom);
      automatic logic [7:0] exp;
      if (op == 0) begin
        @(negedge clk); gpio = v;
        wait_cycles(16);
        m_rise = m_rise | (v & ~m_pins);
        m_fall = m_fall | (~v & m_pins);
        m_pins = v;
      end else if (op == 1) begin
        wr(a, v);
        case (a)
          2'd1:    m_rise = m_rise & ~v;
          2'd2:    m_fall = m_fall & ~v;
          2'd3:    m_mask = v;
          default: ;
        endcase
      end else begin
        case (a)
          2'd0:    exp = m_pins;
          2'd1:    exp = m_rise;
          2'd2:    exp = m_fall;
          default: exp = m_mask;
        endcase
        rd_check($sformatf("rand_rd%0d_adr%0d", it, a), a, exp);
      end
      wait_cycles(2);
      check_eq($sformatf("rand_irq%0d", it), {31'd0, irq},
               {31'd0, |((m_rise | m_fall) & m_mask)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
